cmd_rx_wrapper: RTL and testbench
=================================

// Module: cmd_rx_wrapper
// PURPOSE
//  Slave-side command receiver: consumes the two-byte UART stream produced by the command master
//  (high byte first), assembles a 16-bit command and presents it with a ready flag to the command
//  processor. Also transmits the single 8-bit response byte back to the master.
// PARAMETERS
//  TO_CYC  100000  inter-byte timeout in clk cycles; used only when CMD_RX_TIMEOUT_EN is defined
//  TO_W    17      width of the timeout counter; must satisfy 2**TO_W > TO_CYC
// PORTS
//  clk          in   1   system clock, all logic posedge
//  rst_n        in   1   asynchronous active-low reset
//  RX           in   1   serial input from master
//  TX           out  1   serial output to master, idles high
//  cmd          out  16  assembled command {high,low}; stable while cmd_rdy=1
//  cmd_rdy      out  1   level: valid command held in cmd
//  clr_cmd_rdy  in   1   consumer acknowledge; clears cmd_rdy next clk
//  resp         in   8   response byte to send
//  snd_resp     in   1   one-clk strobe: start response transmission
//  tx_busy      out  1   response transmission in progress
//  resp_sent    out  1   one-clk pulse when response stop bit completes
//  frm_err      out  1   one-clk pulse: partial command discarded on timeout
// BEHAVIOUR
//  Reset (async): cmd=0, cmd_rdy=0, tx_busy=0, resp_sent=0, frm_err=0, TX=1, RX FSM=RX_HIGH,
//   TX FSM=TX_IDLE, timeout counter=0; any partially received byte or command is discarded.
//  RX FSM (byte_rdy = uart rdy):
//   RX_HIGH: byte_rdy -> high_byte<=rx byte, pulse uart clr_rdy, cmd_rdy<=0, -> RX_LOW.
//   RX_LOW : byte_rdy -> cmd<={high_byte,rx byte}, pulse clr_rdy, cmd_rdy<=1, -> RX_HIGH.
//   cmd_rdy rises exactly 1 clk after the low byte's rdy; cmd updates the same edge.
//   cmd_rdy clears on clr_cmd_rdy, or when a new high byte arrives (overwrite; no stall).
//   Simultaneous set (low byte done) and clr_cmd_rdy: set wins, cmd_rdy stays 1.
//   cmd is not modified by a high byte alone; only updated on low-byte completion.
//  TX FSM:
//   TX_IDLE: snd_resp -> latch resp, assert uart trmt for exactly 1 clk, tx_busy<=1, -> TX_SEND.
//   TX_SEND: uart tx_done -> resp_sent pulse 1 clk, tx_busy<=0, -> TX_IDLE.
//   snd_resp while tx_busy=1 is ignored (no queue, latched byte unchanged).
//   RX and TX paths are fully independent; full-duplex operation allowed.
// CONFIGURATION
//  CMD_RX_TIMEOUT_EN defined: counter runs only in RX_LOW, cleared on every state entry and on each
//   byte_rdy; at count==TO_CYC-1 -> discard high byte, frm_err pulse 1 clk, -> RX_HIGH. byte_rdy in
//   the same cycle as expiry takes priority (byte accepted, no frm_err).
//  Not defined: no counter; RX_LOW waits indefinitely; frm_err tied 0 (port still present).
// STRUCTURE
//  Package cmd_rx_pkg: rx_state_t {RX_HIGH,RX_LOW}, tx_state_t {TX_IDLE,TX_SEND},
//   localparam CMD_W=16, BYTE_W=8.
//  One sub-module: existing uart transceiver (trmt, tx_data, tx_done, TX, RX, rdy, rx byte,
//   clr_rdy). All framing/FSM logic lives in this module.
// TESTING
//  1 Master sends 16'hA5C3 (bytes A5,C3) -> cmd_rdy=1 one clk after 2nd rdy, cmd=16'hA5C3.
//  2 clr_cmd_rdy asserted in the cycle the low byte completes -> cmd_rdy remains 1; next
//    clr_cmd_rdy -> 0.
//  3 snd_resp with resp=8'h5A -> TX frame start,5A LSB-first,stop; tx_busy high throughout;
//    one resp_sent pulse; second snd_resp (resp=8'hFF) mid-frame ignored.
//  4 (CMD_RX_TIMEOUT_EN, TO_CYC=1000) send byte 12 only, idle 1000 clk -> one frm_err pulse;
//    then send 34,56 -> cmd=16'h3456.
//  5 rst_n low after byte 78 received -> all outputs reset; after release send 9A,BC ->
//    cmd=16'h9ABC.
//  6 cmd_rdy left high, new command DE,AD sent -> cmd_rdy drops on DE, cmd holds 9ABC until AD,
//    then cmd=16'hDEAD, cmd_rdy=1; response sent concurrently unaffected.

Source files
------------

// File: rtl/cmd_rx_pkg.sv
// Shared types and widths for the command receiver slice.
package cmd_rx_pkg;

   localparam int unsigned CMD_W    = 16;
   localparam int unsigned BYTE_W   = 8;
   // UART bit period in clk cycles
   localparam int unsigned BAUD_CYC = 16;

   typedef enum logic {RX_HIGH, RX_LOW} rx_state_t;
   typedef enum logic {TX_IDLE, TX_SEND} tx_state_t;

endpackage

// File: rtl/cmd_rx_wrapper_uart.sv
// 8N1 UART transceiver: level rdy cleared by clr_rdy, one-clk tx_done at end of stop bit.
module cmd_rx_wrapper_uart
   import cmd_rx_pkg::*;
#(
   parameter int unsigned BAUD = BAUD_CYC
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              trmt,
   input  logic [BYTE_W-1:0] tx_data,
   output logic              tx_done,
   output logic              TX,
   input  logic              RX,
   output logic              rdy,
   output logic [BYTE_W-1:0] rx_data,
   input  logic              clr_rdy
);

   localparam int unsigned CNT_W = $clog2(BAUD);

   logic             rx_ff1, rx_s;
   logic             rx_act;
   logic [CNT_W-1:0] rx_bcnt;
   logic [3:0]       rx_bits;
   logic             tx_act;
   logic [CNT_W-1:0] tx_bcnt;
   logic [3:0]       tx_bits;
   logic [9:0]       tx_shift;

   // Receiver: sync RX, sample each bit at its middle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_ff1  <= 1'b1;
         rx_s    <= 1'b1;
         rx_act  <= 1'b0;
         rx_bcnt <= '0;
         rx_bits <= '0;
         rx_data <= '0;
         rdy     <= 1'b0;
      end else begin
         rx_ff1 <= RX;
         rx_s   <= rx_ff1;
         if (clr_rdy)
            rdy <= 1'b0;
         if (!rx_act) begin
            if (!rx_s) begin
               rx_act  <= 1'b1;
               rx_bcnt <= CNT_W'(BAUD / 2 - 1);
               rx_bits <= '0;
            end
         end else if (rx_bcnt != '0) begin
            rx_bcnt <= rx_bcnt - CNT_W'(1);
         end else begin
            rx_bcnt <= CNT_W'(BAUD - 1);
            rx_bits <= rx_bits + 4'd1;
            if (rx_bits == 4'd0) begin
               if (rx_s)
                  rx_act <= 1'b0;
            end else if (rx_bits == 4'd9) begin
               rx_act <= 1'b0;
               rdy    <= 1'b1;
            end else begin
               rx_data <= {rx_s, rx_data[BYTE_W-1:1]};
            end
         end
      end
   end

   // Transmitter: start, 8 data LSB first, stop; idle line held by all-ones shifter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tx_act   <= 1'b0;
         tx_bcnt  <= '0;
         tx_bits  <= '0;
         tx_shift <= '1;
         tx_done  <= 1'b0;
      end else begin
         tx_done <= 1'b0;
         if (!tx_act) begin
            if (trmt) begin
               tx_act   <= 1'b1;
               tx_shift <= {1'b1, tx_data, 1'b0};
               tx_bcnt  <= CNT_W'(BAUD - 1);
               tx_bits  <= '0;
            end
         end else if (tx_bcnt != '0) begin
            tx_bcnt <= tx_bcnt - CNT_W'(1);
         end else begin
            tx_bcnt  <= CNT_W'(BAUD - 1);
            tx_shift <= {1'b1, tx_shift[9:1]};
            if (tx_bits == 4'd9) begin
               tx_act  <= 1'b0;
               tx_done <= 1'b1;
            end else begin
               tx_bits <= tx_bits + 4'd1;
            end
         end
      end
   end

   assign TX = tx_shift[0];

endmodule

// File: rtl/cmd_rx_wrapper.sv
// Slave command receiver: assembles two UART bytes into a 16-bit command, sends 1-byte responses.
// Optional inter-byte timeout enabled by defining CMD_RX_TIMEOUT_EN.
module cmd_rx_wrapper
   import cmd_rx_pkg::*;
#(
   parameter int unsigned TO_CYC = 100000,
   parameter int unsigned TO_W   = 17
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              RX,
   output logic              TX,
   output logic [CMD_W-1:0]  cmd,
   output logic              cmd_rdy,
   input  logic              clr_cmd_rdy,
   input  logic [BYTE_W-1:0] resp,
   input  logic              snd_resp,
   output logic              tx_busy,
   output logic              resp_sent,
   output logic              frm_err
);

   if ((64'd1 << TO_W) <= 64'(TO_CYC)) begin : g_bad_to_w
      $error("TO_W too narrow for TO_CYC");
   end

   rx_state_t         rx_state, rx_nxt;
   tx_state_t         tx_state, tx_nxt;
   logic              byte_rdy, clr_rdy_c;
   logic [BYTE_W-1:0] rx_byte, high_byte, resp_q;
   logic              trmt, tx_done;
   logic              ld_high_c, ld_cmd_c, to_exp_c;
   logic              tx_start_c, tx_end_c;

   cmd_rx_wrapper_uart #(.BAUD(BAUD_CYC)) u_uart (
      .clk     (clk),
      .rst_n   (rst_n),
      .trmt    (trmt),
      .tx_data (resp_q),
      .tx_done (tx_done),
      .TX      (TX),
      .RX      (RX),
      .rdy     (byte_rdy),
      .rx_data (rx_byte),
      .clr_rdy (clr_rdy_c)
   );

`ifdef CMD_RX_TIMEOUT_EN
   logic [TO_W-1:0] to_cnt;

   // Byte arrival in the expiry cycle wins over the timeout
   assign to_exp_c = (rx_state == RX_LOW) && !byte_rdy && (to_cnt == TO_W'(TO_CYC - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         to_cnt <= '0;
      else if ((rx_state != RX_LOW) || byte_rdy || to_exp_c)
         to_cnt <= '0;
      else
         to_cnt <= to_cnt + TO_W'(1);
   end
`else
   assign to_exp_c = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rx_state <= RX_HIGH;
      else        rx_state <= rx_nxt;
   end

   always_comb begin
      rx_nxt = rx_state;
      case (rx_state)
         RX_HIGH: if (byte_rdy)             rx_nxt = RX_LOW;
         RX_LOW : if (byte_rdy || to_exp_c) rx_nxt = RX_HIGH;
         default:                           rx_nxt = RX_HIGH;
      endcase
   end

   always_comb begin
      clr_rdy_c = byte_rdy;
      ld_high_c = 1'b0;
      ld_cmd_c  = 1'b0;
      case (rx_state)
         RX_HIGH: ld_high_c = byte_rdy;
         RX_LOW : ld_cmd_c  = byte_rdy;
         default: ;
      endcase
   end

   // Command datapath: completion sets cmd_rdy and beats a same-cycle acknowledge
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         high_byte <= '0;
         cmd       <= '0;
         cmd_rdy   <= 1'b0;
         frm_err   <= 1'b0;
      end else begin
         frm_err <= to_exp_c;
         if (ld_high_c)
            high_byte <= rx_byte;
         else if (to_exp_c)
            high_byte <= '0;
         if (ld_cmd_c)
            cmd <= {high_byte, rx_byte};
         if (ld_cmd_c)
            cmd_rdy <= 1'b1;
         else if (ld_high_c || clr_cmd_rdy)
            cmd_rdy <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) tx_state <= TX_IDLE;
      else        tx_state <= tx_nxt;
   end

   always_comb begin
      tx_nxt = tx_state;
      case (tx_state)
         TX_IDLE: if (snd_resp) tx_nxt = TX_SEND;
         TX_SEND: if (tx_done)  tx_nxt = TX_IDLE;
         default:               tx_nxt = TX_IDLE;
      endcase
   end

   always_comb begin
      tx_start_c = 1'b0;
      tx_end_c   = 1'b0;
      case (tx_state)
         TX_IDLE: tx_start_c = snd_resp;
         TX_SEND: tx_end_c   = tx_done;
         default: ;
      endcase
   end

   // Response datapath: strobes while busy are dropped, latched byte untouched
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         resp_q    <= '0;
         trmt      <= 1'b0;
         tx_busy   <= 1'b0;
         resp_sent <= 1'b0;
      end else begin
         trmt      <= tx_start_c;
         resp_sent <= tx_end_c;
         if (tx_start_c) begin
            resp_q  <= resp;
            tx_busy <= 1'b1;
         end else if (tx_end_c) begin
            tx_busy <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_cmd_rx_wrapper.sv
// Directed self-checking bench for cmd_rx_wrapper; timeout cases follow CMD_RX_TIMEOUT_EN.
module tb_cmd_rx_wrapper;
   import cmd_rx_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        RX = 1'b1;
   logic        TX;
   logic [15:0] cmd;
   logic        cmd_rdy;
   logic        clr_cmd_rdy = 1'b0;
   logic [7:0]  resp = 8'h00;
   logic        snd_resp = 1'b0;
   logic        tx_busy, resp_sent, frm_err;

   int checks = 0;
   int errors = 0;
   int sent_cnt = 0;
   int frm_cnt = 0;
   int base;

   cmd_rx_wrapper #(.TO_CYC(1000), .TO_W(10)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .RX          (RX),
      .TX          (TX),
      .cmd         (cmd),
      .cmd_rdy     (cmd_rdy),
      .clr_cmd_rdy (clr_cmd_rdy),
      .resp        (resp),
      .snd_resp    (snd_resp),
      .tx_busy     (tx_busy),
      .resp_sent   (resp_sent),
      .frm_err     (frm_err)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (resp_sent) sent_cnt = sent_cnt + 1;
      if (frm_err)   frm_cnt  = frm_cnt + 1;
   end

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks = checks + 1;
      if (act !== exp) begin
         errors = errors + 1;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      logic [9:0] frame;
      frame = {1'b1, b, 1'b0};
      for (int i = 0; i < 10; i++) begin
         RX = frame[i];
         repeat (BAUD_CYC) @(negedge clk);
      end
   endtask

   // Wait for the low byte's uart rdy, optionally acknowledge in that same cycle
   task automatic watch_low(input logic clr_same, input logic [15:0] exp_cmd);
      logic found;
      found = 1'b0;
      for (int i = 0; i < 12 * BAUD_CYC && !found; i++) begin
         @(negedge clk);
         if (dut.u_uart.rdy) found = 1'b1;
      end
      check("low_rdy_seen", 32'(found), 32'd1);
      if (found) begin
         check("cmd_rdy_before", 32'(cmd_rdy), 32'd0);
         if (clr_same) clr_cmd_rdy = 1'b1;
         @(negedge clk);
         clr_cmd_rdy = 1'b0;
         check("cmd_rdy_after", 32'(cmd_rdy), 32'd1);
         check("cmd_value", 32'(cmd), 32'(exp_cmd));
      end
   endtask

   task automatic check_frame(input logic [7:0] exp, input logic inject);
      logic found;
      found = 1'b0;
      for (int i = 0; i < 4 * BAUD_CYC && !found; i++) begin
         @(negedge clk);
         if (!TX) found = 1'b1;
      end
      check("tx_start_seen", 32'(found), 32'd1);
      if (found) begin
         repeat (BAUD_CYC / 2) @(negedge clk);
         check("tx_start_bit", 32'(TX), 32'd0);
         check("tx_busy_start", 32'(tx_busy), 32'd1);
         for (int b = 0; b < 8; b++) begin
            for (int c = 0; c < BAUD_CYC; c++) begin
               @(negedge clk);
               if (c == 0) snd_resp = 1'b0;
            end
            check($sformatf("tx_bit%0d", b), 32'(TX), 32'(exp[b]));
            if (inject && b == 2) begin
               resp     = 8'hFF;
               snd_resp = 1'b1;
            end
         end
         repeat (BAUD_CYC) @(negedge clk);
         check("tx_stop_bit", 32'(TX), 32'd1);
         check("tx_busy_stop", 32'(tx_busy), 32'd1);
      end
   endtask

   task automatic pulse_resp(input logic [7:0] r);
      @(negedge clk);
      resp     = r;
      snd_resp = 1'b1;
      @(negedge clk);
      snd_resp = 1'b0;
      check("tx_busy_set", 32'(tx_busy), 32'd1);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      check("rst_cmd", 32'(cmd), 32'd0);
      check("rst_cmd_rdy", 32'(cmd_rdy), 32'd0);
      check("rst_tx", 32'(TX), 32'd1);
      check("rst_tx_busy", 32'(tx_busy), 32'd0);
      check("rst_resp_sent", 32'(resp_sent), 32'd0);
      check("rst_frm_err", 32'(frm_err), 32'd0);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);

      // 1: basic command
      send_byte(8'hA5);
      fork
         send_byte(8'hC3);
         watch_low(1'b0, 16'hA5C3);
      join

      // 2: acknowledge collides with completion
      send_byte(8'h13);
      check("t2_rdy_dropped", 32'(cmd_rdy), 32'd0);
      check("t2_cmd_held", 32'(cmd), 32'h0000A5C3);
      fork
         send_byte(8'h57);
         watch_low(1'b1, 16'h1357);
      join
      @(negedge clk);
      clr_cmd_rdy = 1'b1;
      @(negedge clk);
      clr_cmd_rdy = 1'b0;
      check("t2_clr", 32'(cmd_rdy), 32'd0);

      // 3: response frame with mid-frame strobe ignored
      base = sent_cnt;
      pulse_resp(8'h5A);
      check_frame(8'h5A, 1'b1);
      repeat (BAUD_CYC) @(negedge clk);
      check("t3_resp_sent_cnt", 32'(sent_cnt - base), 32'd1);
      check("t3_tx_busy_idle", 32'(tx_busy), 32'd0);
      repeat (4 * BAUD_CYC) @(negedge clk);
      check("t3_no_second_frame", 32'(TX), 32'd1);
      check("t3_still_idle", 32'(tx_busy), 32'd0);

      // 4: inter-byte idle
      base = frm_cnt;
      send_byte(8'h12);
      repeat (1100) @(negedge clk);
`ifdef CMD_RX_TIMEOUT_EN
      check("t4_frm_err_cnt", 32'(frm_cnt - base), 32'd1);
      check("t4_cmd_rdy", 32'(cmd_rdy), 32'd0);
      send_byte(8'h34);
      send_byte(8'h56);
      check("t4_cmd", 32'(cmd), 32'h00003456);
`else
      check("t4_frm_err_cnt", 32'(frm_cnt - base), 32'd0);
      check("t4_cmd_held", 32'(cmd), 32'h00001357);
      send_byte(8'h34);
      check("t4_cmd", 32'(cmd), 32'h00001234);
`endif
      check("t4_cmd_rdy_set", 32'(cmd_rdy), 32'd1);

      // 5: reset with a half command pending
      send_byte(8'h78);
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check("t5_cmd", 32'(cmd), 32'd0);
      check("t5_cmd_rdy", 32'(cmd_rdy), 32'd0);
      check("t5_tx", 32'(TX), 32'd1);
      check("t5_tx_busy", 32'(tx_busy), 32'd0);
      check("t5_frm_err", 32'(frm_err), 32'd0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      send_byte(8'h9A);
      send_byte(8'hBC);
      check("t5_cmd_after", 32'(cmd), 32'h00009ABC);
      check("t5_cmd_rdy_after", 32'(cmd_rdy), 32'd1);

      // 6: overwrite while a response is in flight
      base = sent_cnt;
      fork
         begin
            send_byte(8'hDE);
            check("t6_rdy_dropped", 32'(cmd_rdy), 32'd0);
            check("t6_cmd_held", 32'(cmd), 32'h00009ABC);
            send_byte(8'hAD);
            check("t6_cmd", 32'(cmd), 32'h0000DEAD);
            check("t6_cmd_rdy", 32'(cmd_rdy), 32'd1);
         end
         begin
            pulse_resp(8'h3C);
            check_frame(8'h3C, 1'b0);
            repeat (BAUD_CYC) @(negedge clk);
            check("t6_resp_sent_cnt", 32'(sent_cnt - base), 32'd1);
         end
      join

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
